// File: rtl/weight_rom_reader_pkg.sv
// ---------------------------------------------------------------------------
// weight_rom_reader_pkg
// Shared definitions for the RL weight ROM / GEMM blocks: default ROM
// geometry, the reader FSM state encoding, and a helper that sizes FIFO
// occupancy counters.
// ---------------------------------------------------------------------------
package weight_rom_reader_pkg;

    localparam int WRR_ADDR_W = 8;
    localparam int WRR_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } wrr_state_e;

    // An occupancy counter must represent 0..depth inclusive.
    function automatic int wrr_count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/weight_rom_reader_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// rd_data whenever rd_valid is high; rd_en pops it.
//
// Ports
//   clk, rst      clock, asynchronous active-low reset
//   wr_en/wr_data push request and payload (dropped if full with no pop)
//   rd_en         pop request (ignored when empty)
//   rd_data       head entry
//   rd_valid      FIFO not empty
//   count         current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo
    import weight_rom_reader_pkg::*;
#(
    parameter int WIDTH = WRR_DATA_W,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = wrr_count_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [CW-1:0]    count
);

    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign full     = (count == COUNT_FULL);
    assign rd_valid = (count != '0);
    assign rd_data  = mem[rd_ptr];
    assign do_rd    = rd_en && rd_valid;
    // A push into a full FIFO is fine when the head is leaving the same cycle.
    assign do_wr    = wr_en && (!full || do_rd);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count + {{(CW-1){1'b0}}, do_wr} - {{(CW-1){1'b0}}, do_rd};
        end
    end

endmodule

// File: rtl/weight_rom_reader.sv
// ---------------------------------------------------------------------------
// weight_rom_reader
// Streams a burst of consecutive words out of a synchronous weight ROM onto a
// valid/ready interface. Reads are issued only while the output buffer plus
// the reads still in the ROM pipeline leave room, so no beat is ever lost
// under backpressure.
//
// Ports
//   clk, rst        clock, asynchronous active-low reset
//   start           burst request, sampled only while idle
//   base_addr, len  first address and word count (0..2^ADDR_W), latched on start
//   rom_addr        address presented to the ROM (registered)
//   rom_data        ROM output, valid one cycle after rom_addr
//   m_valid/m_data/m_last/m_ready  output stream
//   busy            burst in progress
//   done            one-cycle pulse when the burst completes
// ---------------------------------------------------------------------------
module weight_rom_reader
    import weight_rom_reader_pkg::*;
#(
    parameter int ADDR_W = WRR_ADDR_W,
    parameter int DATA_W = WRR_DATA_W,
    parameter int FIFO_D = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
);

    localparam int CW = wrr_count_w(FIFO_D);
    localparam logic [CW:0]     OCC_LIMIT = (CW + 1)'(FIFO_D);
    localparam logic [ADDR_W:0] LEN_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    wrr_state_e state;
    wrr_state_e state_next;

    logic [ADDR_W:0] reads_left;
    logic [ADDR_W:0] beats_left;
    logic            rom_valid;
    logic [1:0]      in_flight;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     occupancy;
    logic            issue;
    logic            xfer;
    logic            last_read;
    logic            last_beat;

    // Everything already committed to the buffer: stored words plus reads
    // still travelling through the ROM register.
    assign occupancy = {1'b0, fifo_count} + {{(CW - 1){1'b0}}, in_flight};
    assign xfer      = m_valid && m_ready;
    assign last_read = (reads_left == LEN_ONE);
    assign last_beat = (beats_left == LEN_ONE);
    assign m_last    = m_valid && last_beat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue && last_read) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (xfer && last_beat) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        issue = 1'b0;
        unique case (state)
            ST_IDLE: begin
            end
            ST_RUN: begin
                busy  = 1'b1;
                issue = (occupancy < OCC_LIMIT) && (reads_left != '0);
            end
            ST_DRAIN: begin
                busy = 1'b1;
            end
            ST_FIN: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // rom_addr is loaded with the base on the start edge so the first read
    // is presented to the ROM in the very first RUN cycle. After the final
    // read the address is left where it is.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_addr   <= '0;
            reads_left <= '0;
            beats_left <= '0;
            rom_valid  <= 1'b0;
            in_flight  <= '0;
        end else begin
            rom_valid <= issue;
            in_flight <= in_flight + {1'b0, issue} - {1'b0, rom_valid};
            if (state == ST_IDLE && start && len != '0) begin
                rom_addr   <= base_addr;
                reads_left <= len;
                beats_left <= len;
            end else begin
                if (issue) begin
                    reads_left <= reads_left - LEN_ONE;
                    if (!last_read) begin
                        rom_addr <= rom_addr + ADDR_ONE;
                    end
                end
                if (xfer) begin
                    beats_left <= beats_left - LEN_ONE;
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_D)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (rom_valid),
        .wr_data  (rom_data),
        .rd_en    (m_ready),
        .rd_data  (m_data),
        .rd_valid (m_valid),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_weight_rom_reader.sv
// ---------------------------------------------------------------------------
// tb_weight_rom_reader
// Drives bursts into weight_rom_reader backed by a randomly filled ROM model
// and compares every output cycle against a queue of expected beats built
// from base/len alone.
// ---------------------------------------------------------------------------
module tb_weight_rom_reader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int FIFO_D = 4;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   len = '0;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data = '0;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready = 1'b1;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] rom_mem [256];

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    bit    rand_ready = 1'b0;

    // Literal expectations for the directed bursts (-1 / empty = not pinned).
    int                lit_beats = -1;
    int                lit_done_rel = -1;
    logic [ADDR_W-1:0] lit_addrs [$];

    // Behavioural model state, owned by the compare process.
    beat_t             exp_q [$];
    bit                model_active = 1'b0;
    bit                done_pending = 1'b0;
    int                start_cyc = 0;
    int                cur_len = 0;
    logic [ADDR_W-1:0] cur_base = '0;
    int                beat_idx = 0;
    int                burst_beats = 0;
    int                stall_cnt = 0;
    bit                prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    weight_rom_reader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .FIFO_D (FIFO_D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .busy      (busy),
        .done      (done)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        forever #5 clk = ~clk;
    end

    // Cycle counter used to measure latencies relative to the start cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Synchronous ROM with a one-cycle registered read.
    always @(posedge clk) begin
        rom_data <= rom_mem[rom_addr];
    end

    // Downstream ready: either held high or a fair coin every cycle.
    always @(posedge clk) begin
        #1;
        m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Compare process: checks the DUT against the beat queue on every cycle,
    // then advances the model with what happened this cycle.
    always @(negedge clk) begin : compare
        bit                was_active;
        bit                was_fin;
        int                rel;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] exp_addr;
        if (!rst) begin
            checkOutput("reset_outputs", {36'd0, rom_addr, m_valid, m_last, m_data, busy, done}, 64'd0);
            exp_q.delete();
            model_active = 1'b0;
            done_pending = 1'b0;
            prev_stall   = 1'b0;
            stall_cnt    = 0;
        end else begin
            was_active = model_active;
            was_fin    = done_pending;
            rel        = cyc - start_cyc;

            checkOutput("busy", {63'd0, busy}, {63'd0, model_active});
            checkOutput("done", {63'd0, done}, {63'd0, done_pending});
            if (done_pending) begin
                checkOutput("queue_empty_at_done", 64'(exp_q.size()), 64'd0);
                if (lit_beats >= 0) checkOutput("burst_beats", 64'(burst_beats), 64'(lit_beats));
                if (lit_done_rel >= 0) checkOutput("done_latency", 64'(rel), 64'(lit_done_rel));
                done_pending = 1'b0;
            end

            if (prev_stall) begin
                checkOutput("hold_valid", {63'd0, m_valid}, 64'd1);
                checkOutput("hold_data", {48'd0, m_data}, {48'd0, prev_data});
            end

            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_valid", {63'd0, m_valid}, 64'd0);
                end else begin
                    checkOutput("m_last", {63'd0, m_last}, {63'd0, exp_q[0].last});
                    if (m_ready) begin
                        checkOutput("m_data", {48'd0, m_data}, {48'd0, exp_q[0].data});
                        if (!rand_ready) checkOutput("beat_timing", 64'(rel), 64'(3 + beat_idx));
                        if (exp_q[0].last) begin
                            model_active = 1'b0;
                            done_pending = 1'b1;
                        end
                        void'(exp_q.pop_front());
                        beat_idx++;
                        burst_beats++;
                    end
                end
            end else begin
                checkOutput("m_last_idle", {63'd0, m_last}, 64'd0);
            end

            // With ready held high nothing ever blocks issue, so the k-th
            // cycle after the start edge presents address base+k.
            if (!rand_ready && was_active && rel >= 1 && rel <= cur_len) begin
                if (lit_addrs.size() >= rel) exp_addr = lit_addrs[rel - 1];
                else exp_addr = cur_base + ADDR_W'(rel - 1);
                checkOutput("rom_addr", {56'd0, rom_addr}, {56'd0, exp_addr});
            end

            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;

            if (model_active && !(m_valid && m_ready)) stall_cnt++;
            else stall_cnt = 0;
            if (stall_cnt >= 200) begin
                checkOutput("watchdog_beats_left", 64'(exp_q.size()), 64'd0);
                exp_q.delete();
                model_active = 1'b0;
                stall_cnt    = 0;
            end

            // A start is only honoured when no burst or done pulse is underway.
            if (start && !was_active && !was_fin) begin
                start_cyc   = cyc;
                cur_base    = base_addr;
                cur_len     = int'(len);
                beat_idx    = 0;
                burst_beats = 0;
                if (len == '0) begin
                    done_pending = 1'b1;
                end else begin
                    model_active = 1'b1;
                    for (int i = 0; i < cur_len; i++) begin
                        a = base_addr + ADDR_W'(i);
                        exp_q.push_back('{rom_mem[a], (i == cur_len - 1)});
                    end
                end
            end
        end
    end

    // One-cycle start pulse; the inputs are scrambled afterwards so any
    // failure to latch them shows up in the data.
    task automatic applyStimulus(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = b;
        len       = l;
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = ADDR_W'($urandom);
        len       = (ADDR_W + 1)'($urandom);
    endtask

    task automatic waitIdle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (!model_active && !done_pending) break;
        end
    endtask

    task automatic setLiterals(input int beats, input int done_rel);
        lit_beats    = beats;
        lit_done_rel = done_rel;
        lit_addrs.delete();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom_mem[i] = DATA_W'($urandom);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);

        // Short burst: beats on the 3rd..6th cycles after start, done right after.
        setLiterals(4, 7);
        lit_addrs = '{8'h10, 8'h11, 8'h12, 8'h13};
        applyStimulus(8'h10, 9'd4);
        waitIdle(300);

        // Address wrap at the top of the ROM.
        setLiterals(4, 7);
        lit_addrs = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        applyStimulus(8'hFE, 9'd4);
        waitIdle(300);

        // Empty burst: done one cycle after start, no beats.
        setLiterals(0, 1);
        applyStimulus(8'h33, 9'd0);
        waitIdle(300);

        // Random backpressure plus a start attempt mid-burst that must be ignored.
        setLiterals(16, -1);
        rand_ready = 1'b1;
        applyStimulus(8'h40, 9'd16);
        repeat (4) @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 8'hA0;
        len       = 9'd3;
        @(posedge clk);
        #1 start = 1'b0;
        waitIdle(1000);

        // Reset while the third beat is on the output.
        setLiterals(-1, -1);
        rand_ready = 1'b0;
        applyStimulus(8'h20, 9'd8);
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);

        // Fresh burst after the abort.
        setLiterals(2, 5);
        lit_addrs = '{8'h00, 8'h01};
        applyStimulus(8'h00, 9'd2);
        waitIdle(300);

        // Random bursts under random or full-rate ready.
        for (int t = 0; t < 6; t++) begin
            setLiterals(-1, -1);
            rand_ready = 1'($urandom_range(0, 1));
            applyStimulus(ADDR_W'($urandom), (ADDR_W + 1)'($urandom_range(0, 40)));
            waitIdle(2000);
        end

        // Full-ROM burst with wraparound.
        setLiterals(256, 259);
        rand_ready = 1'b0;
        applyStimulus(8'h80, 9'd256);
        waitIdle(1000);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/weight_rom_reader.md
WEIGHT_ROM_READER -- requirements
Module: weight_rom_reader

Interface
REQ-001 Parameter ADDR_W, default 8, is the ROM address width.
REQ-002 Parameter DATA_W, default 16, is the ROM word width (FP16 weight).
REQ-003 Parameter FIFO_D, default 4, is the output buffer depth (power of two, >=3).
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-low; synchronous deassert is external.
REQ-006 start  in  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-007 base_addr  in  ADDR_W  first ROM address of the burst.
REQ-008 len  in  ADDR_W+1  number of words to read, 0..2^ADDR_W.
REQ-009 rom_addr  out  ADDR_W  address to the synchronous ROM (1-cycle registered read).
REQ-010 rom_data  in  DATA_W  ROM output, valid one cycle after rom_addr.
REQ-011 m_valid / m_data[DATA_W] / m_last  out  stream beat, payload, final-beat flag.
REQ-012 m_ready  in  1  downstream accept; a beat transfers when m_valid and m_ready are both high.
REQ-013 busy  out  1  high from accepted start until done.
REQ-014 done  out  1  one-cycle pulse at burst completion.

Function
REQ-015 FSM states: IDLE, RUN (issuing reads), DRAIN (all reads issued, buffer not yet empty), FIN.
REQ-016 IDLE->RUN on start with len>0; base_addr and len are latched at that edge.
REQ-017 IDLE->FIN on start with len=0; no ROM reads, no beats; done pulses the following cycle.
REQ-018 In RUN, one read is issued per cycle when (fifo_count + in_flight) < FIFO_D; rom_addr advances by 1 per issued read.
REQ-019 Address arithmetic is modulo 2^ADDR_W: 255 wraps to 0 without error.
REQ-020 Issued-read pipeline latency is 2 cycles (addr register -> ROM register -> FIFO write); in_flight counts reads not yet written to the FIFO (0..2).
REQ-021 RUN->DRAIN on the cycle the len-th read issues; DRAIN->FIN when the len-th beat transfers.
REQ-022 FIN lasts exactly one cycle, asserts done, and returns to IDLE; busy drops in the same cycle done is high.
REQ-023 Beats leave in address order; none is dropped or duplicated under any m_ready pattern.
REQ-024 m_valid and m_data hold stable while m_valid=1 and m_ready=0.
REQ-025 m_last is high only with the len-th beat.
REQ-026 With m_ready held high, first m_valid occurs 2 cycles after the start edge and throughput is 1 beat/cycle.
REQ-027 FIFO simultaneous write and read at full occupancy is legal; count is unchanged.
REQ-028 start while busy is ignored; latched base/len are unaffected.
REQ-029 rom_addr holds its last value when no read is issued.

Reset
REQ-030 On rst low: state=IDLE; busy, done, m_valid and m_last are 0; m_data, rom_addr, fifo pointers, fifo_count and in_flight are 0.
REQ-031 Reset mid-burst aborts immediately: the buffer is discarded, no done pulse, and the next start after release begins a fresh burst.

Structure
REQ-032 State encoding and the ADDR_W/DATA_W defaults shall reside in a shared package used by the RL ROM/GEMM blocks.
REQ-033 The output buffer shall be one sub-module, sync_fifo (parameterised width/depth, count output, first-word-fall-through).

Verification
REQ-034 base=0x10, len=4, m_ready=1 -> rom_addr 0x10..0x13; 4 beats matching ROM contents on consecutive cycles starting 2 cycles after start; m_last on beat 4; done 1 cycle after.
REQ-035 base=0xFE, len=4 -> addresses FE, FF, 00, 01 in order.
REQ-036 len=0 -> no m_valid; done pulse 1 cycle after start.
REQ-037 len=16, m_ready random 50% -> all 16 beats in order, data stable while stalled, fifo_count never exceeds 4.
REQ-038 rst low at beat 3 of len=8 -> outputs zero at once, no done; start base=0, len=2 after release -> exactly 2 beats.
REQ-039 len=256, base=0x80, m_ready=1 -> 256 beats, 1/cycle, full wrap, single done.
